core_bus_arbiter: RTL and testbench

//  Shares one single-cycle core register port (cs/we/address/write_data -> read_data/ready)

---
 rtl/core_bus_arbiter_if.sv | 50 +++++
 rtl/core_bus_arbiter.sv | 118 +++++++++++
 tb/tb_core_bus_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_bus_arbiter_if.sv
// Bundle of the two requester ports (m0, m1), the shared core port (s_*)
// and the timeout pulse. The arbiter connects through the slave modport;
// the requesters and the core model connect through the master modport.
interface core_bus_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  // requester m0 (CPU)
  logic              m0_cs;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_address;
  logic [DATA_W-1:0] m0_write_data;
  logic [DATA_W-1:0] m0_read_data;
  logic              m0_ready;
  // requester m1 (secondary engine)
  logic              m1_cs;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_address;
  logic [DATA_W-1:0] m1_write_data;
  logic [DATA_W-1:0] m1_read_data;
  logic              m1_ready;
  // shared core port
  logic              s_cs;
  logic              s_we;
  logic [ADDR_W-1:0] s_address;
  logic [DATA_W-1:0] s_write_data;
  logic [DATA_W-1:0] s_read_data;
  logic              s_ready;
  logic              timeout_err;

  modport slave (
    input  m0_cs, m0_we, m0_address, m0_write_data,
    output m0_read_data, m0_ready,
    input  m1_cs, m1_we, m1_address, m1_write_data,
    output m1_read_data, m1_ready,
    output s_cs, s_we, s_address, s_write_data,
    input  s_read_data, s_ready,
    output timeout_err
  );

  modport master (
    output m0_cs, m0_we, m0_address, m0_write_data,
    input  m0_read_data, m0_ready,
    output m1_cs, m1_we, m1_address, m1_write_data,
    input  m1_read_data, m1_ready,
    input  s_cs, s_we, s_address, s_write_data,
    output s_read_data, s_ready,
    input  timeout_err
  );
endinterface

// File: rtl/core_bus_arbiter.sv
// Round-robin arbiter sharing one single-cycle core register port between
// two requesters. One access in flight; each access is followed by a bubble
// cycle so the winner can drop cs before the next arbitration. A stalled core
// is force-completed with ERR_DATA after TIMEOUT cycles in ACCESS.
module core_bus_arbiter #(
  parameter int                 TIMEOUT  = 16,
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  ERR_DATA = 32'hdeadbeef
) (
  input  logic              clk,
  input  logic              reset,
  core_bus_arbiter_if.slave bus
);

  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;     // 0 = m0, 1 = m1
  logic              last_q, last_d;       // master that last completed normally
  logic [TMR_W-1:0]  timer_q, timer_d;

  logic              g_cs, g_we;
  logic [7:0]        g_address;
  logic [DATA_W-1:0] g_write_data;

  logic              acc_cs, acc_we, acc_rdy, acc_tmo;
  logic [7:0]        acc_address;
  logic [DATA_W-1:0] acc_write_data, acc_rdata;

  // Route the granted requester's signals toward the core.
  always_comb begin
    g_cs         = grant_q ? bus.m1_cs         : bus.m0_cs;
    g_we         = grant_q ? bus.m1_we         : bus.m0_we;
    g_address    = grant_q ? bus.m1_address    : bus.m0_address;
    g_write_data = grant_q ? bus.m1_write_data : bus.m0_write_data;
  end

  // Next-state and access outputs; s_cs never depends on s_ready so a
  // combinational core cannot close a loop through the arbiter.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    timer_d        = timer_q;
    acc_cs         = 1'b0;
    acc_we         = 1'b0;
    acc_address    = '0;
    acc_write_data = '0;
    acc_rdy        = 1'b0;
    acc_tmo        = 1'b0;
    acc_rdata      = '0;
    case (state_q)
      IDLE: begin
        if (bus.m0_cs || bus.m1_cs) begin
          grant_d = (bus.m0_cs && bus.m1_cs) ? ~last_q : bus.m1_cs;
          state_d = ACCESS;
          timer_d = '0;
        end
      end
      ACCESS: begin
        if (!g_cs) begin
          state_d = IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          acc_rdy   = 1'b1;
          acc_tmo   = 1'b1;
          acc_rdata = ERR_DATA;
          state_d   = DONE;
        end else begin
          acc_cs         = 1'b1;
          acc_we         = g_we;
          acc_address    = g_address;
          acc_write_data = g_write_data;
          if (bus.s_ready) begin
            acc_rdy   = 1'b1;
            acc_rdata = bus.s_read_data;
            state_d   = DONE;
            last_d    = grant_q;
          end else if (timer_q != {TMR_W{1'b1}}) begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Drive the bus; everything is held low while reset is asserted.
  always_comb begin
    bus.s_cs         = acc_cs & ~reset;
    bus.s_we         = acc_we & acc_cs & ~reset;
    bus.s_address    = reset ? '0 : acc_address;
    bus.s_write_data = reset ? '0 : acc_write_data;
    bus.m0_ready     = acc_rdy & ~grant_q & ~reset;
    bus.m1_ready     = acc_rdy &  grant_q & ~reset;
    bus.m0_read_data = (acc_rdy & ~grant_q & ~reset) ? acc_rdata : '0;
    bus.m1_read_data = (acc_rdy &  grant_q & ~reset) ? acc_rdata : '0;
    bus.timeout_err  = acc_tmo & ~reset;
  end

  // Control state register; m0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: directed scenarios plus randomized traffic
// from two requesters against a behavioural core with random ready delay.
module tb_core_bus_arbiter;
  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hdeadbeef;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   we_cycles = 0;

  core_bus_arbiter_if bus ();

  core_bus_arbiter #(.TIMEOUT(TIMEOUT), .DATA_W(32), .ERR_DATA(ERR_DATA)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tmo;
    int          ecyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          ord_q[$];
  logic [31:0] shadow [256];

  function automatic logic [31:0] init_val(input int a);
    return (a == 0) ? 32'h6d746131 : (32'h5a000000 ^ (32'(a) * 32'h00010203));
  endfunction

  // ---------------- behavioural core ----------------
  logic        core_dead = 1'b0;
  int          max_delay = 0;
  int          cur_delay;
  int          wcnt;
  logic [31:0] mem [256];

  assign bus.s_ready     = bus.s_cs && !core_dead && (wcnt >= cur_delay);
  assign bus.s_read_data = bus.s_cs ? mem[bus.s_address] : 32'h0;

  always @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < 256; j++) mem[j] <= init_val(j);
      wcnt      <= 0;
      cur_delay <= 0;
    end else if (bus.s_cs && bus.s_ready) begin
      if (bus.s_we) mem[bus.s_address] <= bus.s_write_data;
      wcnt      <= 0;
      cur_delay <= int'($urandom_range(max_delay));
    end else if (bus.s_cs) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_zero(input string n);
    chk({n, "_ctl"}, {27'd0, bus.s_cs, bus.s_we, bus.m0_ready, bus.m1_ready, bus.timeout_err}, 32'd0);
    chk({n, "_data"}, bus.s_write_data | bus.m0_read_data | bus.m1_read_data | {24'd0, bus.s_address}, 32'd0);
  endtask

  task automatic init_shadow();
    for (int j = 0; j < 256; j++) shadow[j] = init_val(j);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic cs, input logic we, input logic [7:0] a, input logic [31:0] wd);
    if (i == 0) begin
      bus.m0_cs = cs; bus.m0_we = we; bus.m0_address = a; bus.m0_write_data = wd;
    end else begin
      bus.m1_cs = cs; bus.m1_we = we; bus.m1_address = a; bus.m1_write_data = wd;
    end
  endtask

  function automatic logic ready_of(input int i);
    return (i == 0) ? bus.m0_ready : bus.m1_ready;
  endfunction

  // Issue one access, push its expected completion, hold cs until ready.
  task automatic issue(input int i, input logic [7:0] a, input logic we, input logic [31:0] wd,
                       input logic tmo, input int ecyc);
    exp_t e;
    bit   got;
    e.addr = a; e.we = we; e.wdata = wd; e.tmo = tmo; e.ecyc = ecyc;
    e.rdata = tmo ? ERR_DATA : shadow[a];
    if (we && !tmo) shadow[a] = wd;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
    set_req(i, 1'b1, we, a, wd);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = ready_of(i);
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL req_wait m%0d addr=%h actual=no_ready required=ready", i, a);
    end
    tick();
    set_req(i, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic do_reset();
    chk("pending_before_reset", 32'(q0.size() + q1.size() + ord_q.size()), 32'd0);
    q0.delete(); q1.delete(); ord_q.delete();
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
    set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
    core_dead = 1'b0;
    max_delay = 0;
    init_shadow();
    @(negedge clk);
    check_zero("in_reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_zero("after_reset");
    tick();
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check_done(input int i);
    exp_t        e;
    logic [31:0] rd;
    rd = (i == 0) ? bus.m0_read_data : bus.m1_read_data;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL unexpected_ready m%0d actual=ready required=none (cycle %0d)", i, cyc);
    end else begin
      e = (i == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("m%0d_rdata", i), rd, e.rdata);
      chk($sformatf("m%0d_timeout_err", i), 32'(bus.timeout_err), 32'(e.tmo));
      if (!e.tmo) begin
        chk($sformatf("m%0d_s_cs", i), 32'(bus.s_cs), 32'd1);
        chk($sformatf("m%0d_s_address", i), 32'(bus.s_address), 32'(e.addr));
        chk($sformatf("m%0d_s_we", i), 32'(bus.s_we), 32'(e.we));
        if (e.we) chk($sformatf("m%0d_s_write_data", i), bus.s_write_data, e.wdata);
      end else begin
        chk($sformatf("m%0d_tmo_s_cs", i), 32'(bus.s_cs), 32'd0);
      end
      if (e.ecyc >= 0) chk($sformatf("m%0d_ready_cycle", i), 32'(cyc), 32'(e.ecyc));
    end
    if (ord_q.size() > 0) chk("grant_order", 32'(i), 32'(ord_q.pop_front()));
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("we_without_cs", 32'(bus.s_we & ~bus.s_cs), 32'd0);
      chk("both_ready", 32'(bus.m0_ready & bus.m1_ready), 32'd0);
      chk("tmo_without_ready", 32'(bus.timeout_err & ~(bus.m0_ready | bus.m1_ready)), 32'd0);
      if (!bus.m0_ready) chk("m0_idle_data", bus.m0_read_data, 32'd0);
      if (!bus.m1_ready) chk("m1_idle_data", bus.m1_read_data, 32'd0);
      if (bus.s_we) we_cycles++;
      if (bus.m0_ready) check_done(0);
      if (bus.m1_ready) check_done(1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int s;
    int w0;
    do_reset();

    // single read by m0, same-cycle core
    s = cyc;
    issue(0, 8'h00, 1'b0, 32'h0, 1'b0, s + 1);

    // both requesting back to back: strict alternation, 3 cycles per access
    do_reset();
    s = cyc;
    for (int j = 0; j < 8; j++) ord_q.push_back(j % 2);
    fork
      for (int j = 0; j < 4; j++) issue(0, 8'(j), 1'b0, 32'h0, 1'b0, s + 1 + 6 * j);
      for (int j = 0; j < 4; j++) issue(1, 8'(8'h80 + j), 1'b0, 32'h0, 1'b0, s + 4 + 6 * j);
    join

    // m1 write, exactly one s_we cycle, then read it back
    do_reset();
    w0 = we_cycles;
    s = cyc;
    issue(1, 8'h09, 1'b1, 32'h5, 1'b0, s + 1);
    chk("write_we_cycles", 32'(we_cycles - w0), 32'd1);
    issue(1, 8'h09, 1'b0, 32'h0, 1'b0, -1);

    // stalled core: forced completion, then back through IDLE
    do_reset();
    core_dead = 1'b1;
    s = cyc;
    issue(0, 8'h20, 1'b0, 32'h0, 1'b1, s + TIMEOUT);
    core_dead = 1'b0;
    s = cyc;
    issue(0, 8'h21, 1'b0, 32'h0, 1'b0, s + 2);

    // m0 aborts mid-access; pending m1 served next
    do_reset();
    core_dead = 1'b1;
    s = cyc;
    ord_q.push_back(1);
    fork
      begin
        set_req(0, 1'b1, 1'b0, 8'h10, 32'h0);
        tick(); tick(); tick();
        set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
        core_dead = 1'b0;
        @(negedge clk);
        chk("abort_s_cs", 32'(bus.s_cs), 32'd0);
      end
      begin
        tick();
        issue(1, 8'h90, 1'b0, 32'h0, 1'b0, s + 5);
      end
    join

    // abort leaves the round-robin pointer alone
    do_reset();
    issue(0, 8'h11, 1'b0, 32'h0, 1'b0, -1);
    core_dead = 1'b1;
    set_req(1, 1'b1, 1'b0, 8'h91, 32'h0);
    tick(); tick(); tick(); tick();
    set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
    core_dead = 1'b0;
    tick(); tick();
    s = cyc;
    ord_q.push_back(1);
    ord_q.push_back(0);
    fork
      issue(0, 8'h12, 1'b0, 32'h0, 1'b0, s + 4);
      issue(1, 8'h92, 1'b0, 32'h0, 1'b0, s + 1);
    join

    // reset in the middle of an access
    do_reset();
    core_dead = 1'b1;
    set_req(0, 1'b1, 1'b1, 8'h30, 32'h1234);
    tick(); tick();
    reset = 1'b1;
    @(negedge clk);
    check_zero("reset_mid_access");
    tick();
    set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
    init_shadow();
    core_dead = 1'b0;
    tick();
    reset = 1'b0;
    s = cyc;
    ord_q.push_back(0);
    ord_q.push_back(1);
    fork
      issue(0, 8'h31, 1'b0, 32'h0, 1'b0, s + 1);
      issue(1, 8'hb1, 1'b0, 32'h0, 1'b0, s + 4);
      begin
        @(negedge clk);
        check_zero("first_cycle_after_reset");
      end
    join

    // randomized traffic; each master owns half of the address space
    do_reset();
    max_delay = 3;
    fork
      for (int j = 0; j < 30; j++) begin
        repeat ($urandom_range(3)) tick();
        issue(0, {1'b0, 7'($urandom)}, 1'($urandom), $urandom, 1'b0, -1);
      end
      for (int j = 0; j < 30; j++) begin
        repeat ($urandom_range(3)) tick();
        issue(1, {1'b1, 7'($urandom)}, 1'($urandom), $urandom, 1'b0, -1);
      end
    join
    tick(); tick();
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
